// File: rtl/tbird_pkg.sv
// tbird_pkg: shared state encoding, lamp bit positions and lamp patterns
// for the tail-light sequencer.
package tbird_pkg;

    typedef enum logic [3:0] {IDLE, LA, LB, LC, RA, RB, RC, HON, HOFF} state_t;

    localparam int L1_BIT = 3;
    localparam int L2_BIT = 4;
    localparam int L3_BIT = 5;
    localparam int R1_BIT = 2;
    localparam int R2_BIT = 1;
    localparam int R3_BIT = 0;

    localparam logic [5:0] PAT_LA = 6'(1 << L1_BIT);
    localparam logic [5:0] PAT_LB = PAT_LA | 6'(1 << L2_BIT);
    localparam logic [5:0] PAT_LC = PAT_LB | 6'(1 << L3_BIT);
    localparam logic [5:0] PAT_RA = 6'(1 << R1_BIT);
    localparam logic [5:0] PAT_RB = PAT_RA | 6'(1 << R2_BIT);
    localparam logic [5:0] PAT_RC = PAT_RB | 6'(1 << R3_BIT);

    function automatic logic [5:0] leds_of(state_t s);
        return s == LA   ? PAT_LA :
               s == LB   ? PAT_LB :
               s == LC   ? PAT_LC :
               s == RA   ? PAT_RA :
               s == RB   ? PAT_RB :
               s == RC   ? PAT_RC :
               s == HON  ? 6'h3f  : 6'h00;
    endfunction

endpackage

// File: rtl/tbird_led_sequencer_sync2.sv
// sync2: two-flop synchronizer for one asynchronous switch input.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) {q, meta} <= 2'b00;
        else        {q, meta} <= {meta, d};
    end

endmodule

// File: rtl/tbird_led_sequencer.sv
// tbird_led_sequencer: frame-paced turn/hazard lamp sequencer.
// Define HAZARD_EN to add the dedicated hazard switch input.
import tbird_pkg::*;

module tbird_led_sequencer #(
    parameter int FRAMES_PER_STEP = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] vcount,
    input  logic       left,
    input  logic       right,
`ifdef HAZARD_EN
    input  logic       hazard,
`endif
    output logic [5:0] LEDS,
    output logic       step_tick,
    output logic [3:0] state_dbg
);

    logic       left_s, right_s, hazard_s;
    logic [9:0] vcount_q;
    logic [5:0] frame_cnt;
    logic       frame_tick;
    state_t     state, state_next;

    sync2 u_left  (.clk(clk), .rst_n(rst_n), .d(left),  .q(left_s));
    sync2 u_right (.clk(clk), .rst_n(rst_n), .d(right), .q(right_s));
`ifdef HAZARD_EN
    sync2 u_hazard (.clk(clk), .rst_n(rst_n), .d(hazard), .q(hazard_s));
`else
    assign hazard_s = 1'b0;
`endif

    // Tick on the first line-0 cycle of a frame only; a held zero does not retrigger.
    assign frame_tick = rst_n && vcount == '0 && vcount_q != '0;
    assign step_tick  = frame_tick && frame_cnt == 6'(FRAMES_PER_STEP - 1);
    assign state_dbg  = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vcount_q  <= '0;
            frame_cnt <= '0;
            state     <= IDLE;
            LEDS      <= '0;
        end else begin
            vcount_q <= vcount;
            if (frame_tick) frame_cnt <= step_tick ? 6'd0 : frame_cnt + 6'd1;
            if (step_tick) begin
                state <= state_next;
                LEDS  <= leds_of(state_next);
            end
        end
    end

    // Hazard and both-high share the HON/HOFF alternation, so one branch serves both.
    always_comb begin
        state_next = IDLE;
        if (hazard_s || (left_s && right_s))
            state_next = state == HON ? HOFF : HON;
        else if (left_s)
            state_next = state == IDLE ? LA : state == LA ? LB : state == LB ? LC : IDLE;
        else if (right_s)
            state_next = state == IDLE ? RA : state == RA ? RB : state == RB ? RC : IDLE;
    end

endmodule

// File: tb/tb_tbird_led_sequencer.sv
// tb_tbird_led_sequencer: scoreboard bench; expected lamp/state per step are
// queued by the driver and compared by a monitor on every step_tick.
import tbird_pkg::*;

module tb_tbird_led_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] vcount;
    logic       left, right, hazard;
    logic [5:0] LEDS;
    logic       step_tick;
    logic [3:0] state_dbg;

    typedef struct {
        logic [5:0] leds;
        state_t     st;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   steps_seen = 0;
    int   wraps = 0;
    int   held = 0;
    logic hold_zero = 1'b0;

    tbird_led_sequencer #(.FRAMES_PER_STEP(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .vcount(vcount),
        .left(left),
        .right(right),
`ifdef HAZARD_EN
        .hazard(hazard),
`endif
        .LEDS(LEDS),
        .step_tick(step_tick),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // VGA line counter 0..524; optionally parks on line 0 for several cycles.
    initial begin
        vcount = 10'd100;
        forever begin
            @(posedge clk);
            #1;
            if (vcount == 10'd0 && hold_zero && held < 6) begin
                held++;
            end else begin
                held = 0;
                vcount = vcount == 10'd524 ? 10'd0 : vcount + 10'd1;
                if (vcount == 10'd0) wraps++;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (step_tick) begin
                check($sformatf("frames#%0d", steps_seen), wraps, 2);
                wraps = 0;
                @(negedge clk);
                check($sformatf("pulse#%0d", steps_seen), int'(step_tick), 0);
                if (exp_q.size() == 0) begin
                    check($sformatf("unexpected_step#%0d", steps_seen), 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("leds#%0d", steps_seen), int'(LEDS), int'(e.leds));
                    check($sformatf("state#%0d", steps_seen), int'(state_dbg), int'(e.st));
                end
                steps_seen++;
            end
        end
    end

    task automatic expect_step(input logic [5:0] l, input state_t s);
        int target;
        int n;
        target = steps_seen + 1;
        n = 0;
        exp_q.push_back('{l, s});
        while (steps_seen < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (steps_seen < target) check("step_timeout", steps_seen, target);
    endtask

    task automatic reset_check(input string tag);
        @(negedge clk);
        check({tag, "_leds"}, int'(LEDS), 0);
        check({tag, "_state"}, int'(state_dbg), int'(IDLE));
        check({tag, "_tick"}, int'(step_tick), 0);
        rst_n = 1'b1;
        wraps = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        left = 1'b0;
        right = 1'b0;
        hazard = 1'b0;
        repeat (4) @(negedge clk);
        reset_check("reset");

        left = 1'b1;
        repeat (2) begin
            expect_step(6'b001000, LA);
            expect_step(6'b011000, LB);
            expect_step(6'b111000, LC);
            expect_step(6'b000000, IDLE);
        end

        expect_step(6'b001000, LA);
        expect_step(6'b011000, LB);
        left = 1'b0;
        right = 1'b1;
        hold_zero = 1'b1;
        expect_step(6'b000000, IDLE);
        expect_step(6'b000100, RA);
        expect_step(6'b000110, RB);
        right = 1'b0;
        expect_step(6'b000000, IDLE);
        hold_zero = 1'b0;

        left = 1'b1;
        expect_step(6'b001000, LA);
        left = 1'b0;
        expect_step(6'b000000, IDLE);

        left = 1'b1;
        right = 1'b1;
        expect_step(6'b111111, HON);
        expect_step(6'b000000, HOFF);
        expect_step(6'b111111, HON);
        left = 1'b0;
        right = 1'b0;
        expect_step(6'b000000, IDLE);

`ifdef HAZARD_EN
        right = 1'b1;
        expect_step(6'b000100, RA);
        expect_step(6'b000110, RB);
        hazard = 1'b1;
        expect_step(6'b111111, HON);
        expect_step(6'b000000, HOFF);
        hazard = 1'b0;
        right = 1'b0;
        expect_step(6'b000000, IDLE);
`endif

        left = 1'b1;
        expect_step(6'b001000, LA);
        expect_step(6'b011000, LB);
        expect_step(6'b111000, LC);
        repeat (600) @(negedge clk);
        rst_n = 1'b0;
        reset_check("midreset");
        expect_step(6'b001000, LA);
        left = 1'b0;
        expect_step(6'b000000, IDLE);

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tbird_led_sequencer.md
TBIRD_LED_SEQUENCER -- requirements
Module: tbird_led_sequencer

Interface
REQ-001 SHALL have parameter FRAMES_PER_STEP, default 12: frame ticks per sequence step, legal range 1..63.
REQ-002 SHALL have port clk, input, 1: single system clock, pixel-clock domain.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port vcount, input, 10: vertical line count from the VGA timing block.
REQ-005 SHALL have port left, input, 1: asynchronous left-turn switch.
REQ-006 SHALL have port right, input, 1: asynchronous right-turn switch.
REQ-007 SHALL have port hazard, input, 1: asynchronous hazard switch; present only when HAZARD_EN is defined.
REQ-008 SHALL have port LEDS, output, 6: lamp vector for the bit generator; [3]=L1, [4]=L2, [5]=L3, [2]=R1, [1]=R2, [0]=R3.
REQ-009 SHALL have port step_tick, output, 1: one-cycle pulse on each state advance.
REQ-010 SHALL have port state_dbg, output, 4: current state encoding.

Function
REQ-011 SHALL pass left, right and hazard each through a two-flop synchronizer before use.
REQ-012 SHALL raise an internal frame tick for exactly one cycle when vcount equals 0 and its previous-cycle registered value was nonzero.
REQ-013 SHALL count frame ticks in a 6-bit counter and assert step_tick on the cycle the count reaches FRAMES_PER_STEP-1 while a tick is present, then wrap the counter to 0.
REQ-014 SHALL have FSM states IDLE, LA, LB, LC, RA, RB, RC, HON and HOFF, and SHALL change state only on a step_tick cycle.
REQ-015 SHALL drive LEDS from a register updated on the same edge as the state: IDLE=000000, LA=001000, LB=011000, LC=111000, RA=000100, RB=000110, RC=000111, HON=111111, HOFF=000000.
REQ-016 SHALL, on each step, evaluate transition priority in this order: hazard; left and right both high; left only; right only; none.
REQ-017 SHALL move from any state to HON, and from HON to HOFF, on a step when hazard is high; HOFF SHALL return to HON while hazard stays high.
REQ-018 SHALL transition from LC or RC to IDLE, so each sequence ends with one dark step.
REQ-019 SHALL advance a started sequence through its states (IDLE→LA→LB→LC, IDLE→RA→RB→RC) only while its request stays high; if the request drops, the next step SHALL go to IDLE.
REQ-020 SHALL, when the opposite request is active alone mid-sequence, go to IDLE on the next step and start the new side one step later.
REQ-021 SHALL treat left and right both high, without hazard, as the hazard pair: HON, then HOFF, alternating.
REQ-022 SHALL move HON or HOFF to IDLE on a step when hazard and both-high are released.
REQ-023 SHALL have state_dbg reflect the registered state with zero latency.

Reset
REQ-024 SHALL, when rst_n is low at a clk edge, set the state to IDLE, LEDS to 000000, step_tick to 0, the frame counter to 0, the synchronizers to 0 and the vcount history to 0.
REQ-025 SHALL override any in-progress sequence with reset, and SHALL produce the first step_tick FRAMES_PER_STEP frame ticks after rst_n deasserts.

Configuration
REQ-026 SHALL, with `HAZARD_EN defined, include the hazard port, its synchronizer and the hazard branch of REQ-016.
REQ-027 SHALL, without HAZARD_EN, omit the hazard port and logic; HON and HOFF SHALL then be reachable only through both-high per REQ-021.

Structure
REQ-028 SHALL place the state enumeration, the six LEDS pattern constants and the lamp bit-index constants in shared package tbird_pkg.
REQ-029 SHALL implement the synchronizer as one sub-module, sync2, instanced once per switch.

Verification (bench uses FRAMES_PER_STEP=2 and a vcount model that wraps 0..524)
REQ-030 SHALL cover this case: left held for 8 steps → LEDS sequence 001000, 011000, 111000, 000000, repeated, one change per step_tick.
REQ-031 SHALL cover this case: right raised during LB → next step IDLE 000000, then 000100, then 000110.
REQ-032 SHALL cover this case: left and right high together → 111111 and 000000 alternating each step; both released during HON → HOFF is skipped and the next step gives IDLE.
REQ-033 SHALL cover this case: hazard asserted during RB (HAZARD_EN defined) → next step 111111 regardless of left/right.
REQ-034 SHALL cover this case: rst_n low for one cycle mid-LC → LEDS=000000 and state_dbg=IDLE on the next edge, with no step_tick until 2 frame ticks later.
REQ-035 SHALL cover this case: vcount held at 0 for several cycles → exactly one frame tick is counted.
